seven_seg_scan_driver: RTL
==========================

Name: seven_seg_scan_driver

Overview:
- Time-multiplexed successor to the static per-digit BCD seven-segment decoder. It is parametrised in digit count and drives one shared segment bus plus per-digit enables.
- It double-buffers the BCD value through a valid/ready handshake. New values swap in only at frame boundaries, so the display never tears.
- It adds dead-time anti-ghosting and leading-zero blanking. Digit blinking is available as an optional feature.
- It sits between the timekeeping/BCD logic and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2.
- DEAD_CYCLES, 16, cycles at the start of each slot with all digits disabled; must be < SCAN_DIV.
- BLINK_FRAMES, 32, frames per blink half-period; used only with the optional feature.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- bcd_in, input, 4*NUM_DIGITS, packed BCD value; nibble k drives digit k, and nibble 0 (bits [3:0]) is the least significant digit.
- update_valid, input, 1, a new bcd_in value is offered.
- update_ready, output, 1, the pending buffer is free.
- lz_blank, input, 1, enables leading-zero suppression.
- blink_mask, input, NUM_DIGITS, per-digit blink select; ignored unless the feature is enabled.
- seg, output, 7, segments {a,b,c,d,e,f,g}, active low.
- dig_en, output, NUM_DIGITS, digit enables, active low, at most one low at a time.
- frame_done, output, 1, one-cycle pulse after the last slot of each frame.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - seg = 7'b1111111, dig_en = all 1s, frame_done = 0, update_ready = 1.
  - Active buffer = all nibbles 4'hF (blank), pending flag = 0.
  - Slot counter cnt = 0, digit index idx = 0, blink phase = 0, frame counter = 0.
- Reset asserted mid-frame or mid-handshake discards the pending data and returns to these values on the next edge.
- Scan counters:
  - cnt counts 0..SCAN_DIV-1.
  - On wrap, idx advances and wraps from NUM_DIGITS-1 to 0.
  - Frame boundary: the edge where idx = NUM_DIGITS-1 and cnt = SCAN_DIV-1.
- seg and dig_en are registered from the next-state values of (idx, cnt). In the cycle where the internal state is (i, c), the outputs reflect (i, c).
- dig_en[i] is low iff c >= DEAD_CYCLES; all enables are high during dead time.
- seg during dead time is 1111111.
- Decode table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Nibbles 10..15 decode to 1111111 (blank).
- Leading-zero suppression (lz_blank=1):
  - Scanning from digit NUM_DIGITS-1 downward, zero nibbles are blanked until the first non-zero nibble.
  - Digit 0 is never blanked by this rule.
  - lz_blank is sampled live each cycle.
- Handshake:
  - update_ready = !pending.
  - Transfer when update_valid && update_ready: bcd_in is captured into the pending buffer and pending is set. update_ready goes low on the next cycle.
  - update_valid while update_ready=0 is ignored; the source must hold the value.
- At the frame boundary edge:
  - If pending=1, active <= pending buffer and pending <= 0.
  - frame_done = 1 for the following cycle.
  - Digit 0 of the new frame shows the new value.
- Simultaneous transfer and frame boundary edge: only possible with pending=0. The capture lands in pending and swaps at the next frame boundary, never the current one.

Optional Feature:
- Macro: SEVEN_SEG_BLINK_EN.
- Defined:
  - A frame counter counts frame boundaries 0..BLINK_FRAMES-1.
  - On wrap, the blink phase toggles.
  - While phase=1, any slot whose blink_mask bit is 1 drives seg=1111111; dig_en timing is unchanged.
  - frame_done is unaffected.
- Undefined: no frame counter or phase register is built. blink_mask is present but unused, and the display is never blinked.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2.
1. Reset held 3 cycles, then released, no update -> seg=1111111 and update_ready=1 throughout. dig_en cycles 1110/1101/1011/0111 in cycles 1..3 of each slot and is 1111 in cycle 0. frame_done pulses every 16 cycles.
2. update_valid=1 with bcd_in=16'h1234 at idx=2, cnt=1 -> update_ready=0 next cycle. frame_done pulses after the boundary. Next frame shows seg sequence 1001100, 0000110, 0010010, 1001111 for digits 0..3. update_ready returns to 1 after the swap.
3. After swap, a second offer 16'h9999 while pending, then a new offer 16'h0070 accepted with lz_blank=1 -> the 9999 offer is not taken (ready low). After the 0070 swap, digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001. Changing lz_blank to 0 takes effect in the next cycle: digits 3 and 2 show 0000001.
4. bcd_in=16'h5A0F -> digit 0 blank, digit 1 0000001, digit 2 blank, digit 3 0100100.
5. Reset asserted at idx=1, cnt=2 with pending=1 -> on the next edge seg=1111111, dig_en=1111, update_ready=1, and the pending value is lost.
6. With SEVEN_SEG_BLINK_EN defined, value 16'h1111 and blink_mask=4'b0001 -> digit 0 shows 1001111 for frames 0-1 and 1111111 for frames 2-3, repeating. Digits 1-3 are constant at 1001111. Without the macro, digit 0 is constant.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered BCD, dead-time, leading-zero blanking.
// Optional digit blinking is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    update_valid,
  output logic                    update_ready,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUF_W-1:0]      active_q, active_d;
  logic [BUF_W-1:0]      pend_buf_q, pend_buf_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic                  xfer;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  blink_phase_d;

  assign boundary = (idx_q == LAST_IDX) && (cnt_q == LAST_CNT);
  assign xfer     = update_valid && !pending_q;

  // Scan position
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Capture into the pending buffer; the swap happens only on the frame boundary
  always_comb begin
    pend_buf_d   = pend_buf_q;
    pending_d    = pending_q;
    active_d     = active_q;
    frame_done_d = boundary;
    if (xfer) begin
      pend_buf_d = bcd_in;
      pending_d  = 1'b1;
    end
    if (boundary && pending_q) begin
      active_d  = pend_buf_q;
      pending_d = 1'b0;
    end
  end

  // Leading zeros are judged on the buffer that will be on display next cycle
  always_comb begin
    logic seen_nz;
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (active_d[4*k +: 4] != 4'h0) seen_nz = 1'b1;
      if (k != 0) lz_mask[k] = lz_blank && !seen_nz;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (boundary) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_phase_d = phase_d;
`else
  assign blink_phase_d = 1'b0;
`endif

  // Outputs are computed from next-state values so they line up with the state they describe
  always_comb begin
    logic [3:0] nib;
    logic       sel_blank;
    logic       lit;
    seg_d     = SEG_OFF;
    dig_en_d  = '1;
    nib       = 4'hF;
    sel_blank = 1'b0;
    lit       = (cnt_d >= DEAD_CNT);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib       = active_d[4*k +: 4];
        sel_blank = lz_mask[k] || (blink_phase_d && blink_mask[k]);
        if (lit) dig_en_d[k] = 1'b0;
      end
    end
    if (lit && !sel_blank) seg_d = bcd_to_seg(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '1;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pending data is qualified by pending_q, so it needs no reset
  always_ff @(posedge clk) begin
    pend_buf_q <= pend_buf_d;
  end

  assign update_ready = !pending_q;
  assign seg          = seg_q;
  assign dig_en       = dig_en_q;
  assign frame_done   = frame_done_q;

endmodule
